// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the digit-serial adder sequencer.
// Contents:
//   seq_state_t       - sequencer states (IDLE, RUN, DONE)
//   calc_num_digits   - number of digits a word splits into
//   calc_cnt_width    - digit counter width, at least one bit
//   widths_divide     - true when the word splits into whole digits
package multiword_adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int calc_num_digits(input int data_w, input int digit_w);
    return data_w / digit_w;
  endfunction

  // A single-digit word still keeps a one-bit counter so the sequencing
  // logic does not need a special case.
  function automatic int calc_cnt_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

  function automatic bit widths_divide(input int data_w, input int digit_w);
    return (digit_w > 0) && ((data_w % digit_w) == 0);
  endfunction

endpackage

// File: rtl/multiword_adder_seq_ripple.sv
// Combinational ripple-carry adder built from a chain of full adders.
// Ports:
//   a, b  - WIDTH-bit addends
//   ci    - carry into bit 0
//   s     - WIDTH-bit sum
//   co    - carry out of the top bit
module multiword_adder_seq_ripple
  import multiword_adder_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  // The carry is a block-local variable so the chain is evaluated in bit
  // order inside one process rather than as a feedback vector.
  always_comb begin : ripple_chain
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/multiword_adder_seq.sv
// Digit-serial adder sequencer. Accepts one operand pair, adds it one digit
// per cycle (least-significant first) on a shared DIGIT_WIDTH adder and
// presents the full sum and carry-out on an output handshake.
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   a_in, b_in       - DATA_WIDTH operands
//   ci_in            - carry into digit 0
//   in_vld, in_rd    - input handshake (ready only while idle)
//   s_out, co_out    - sum and carry-out of the most significant digit
//   out_vld, out_rd  - result handshake
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  ci_in,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] s_out,
  output logic                  co_out,
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int NUM_DIGITS = calc_num_digits(DATA_WIDTH, DIGIT_WIDTH);
  localparam int CNT_W      = calc_cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  if (!widths_divide(DATA_WIDTH, DIGIT_WIDTH)) begin : g_width_check
    $error("multiword_adder_seq: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
  end

  seq_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]  a_q, b_q, result_q;
  logic                   carry_q;
  logic [CNT_W-1:0]       digit_cnt_q;
  logic [DIGIT_WIDTH-1:0] digit_sum;
  logic                   digit_co;

  multiword_adder_seq_ripple #(
    .WIDTH(DIGIT_WIDTH)
  ) u_digit_adder (
    .a  (a_q[DIGIT_WIDTH-1:0]),
    .b  (b_q[DIGIT_WIDTH-1:0]),
    .ci (carry_q),
    .s  (digit_sum),
    .co (digit_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept while idle, run for exactly NUM_DIGITS cycles,
  // then hold the result until the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_vld)                    state_d = RUN;
      RUN:     if (digit_cnt_q == LAST_DIGIT) state_d = DONE;
      DONE:    if (out_rd)                    state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Operand, result, carry and digit-count registers. Each RUN cycle the
  // operands move down one digit so the adder always sees the next digit in
  // the low bits, and the new sum digit enters the result from the top; after
  // the last digit the result register holds the full sum in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      digit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_vld) begin
            a_q         <= a_in;
            b_q         <= b_in;
            carry_q     <= ci_in;
            digit_cnt_q <= '0;
          end
        end
        RUN: begin
          a_q         <= a_q >> DIGIT_WIDTH;
          b_q         <= b_q >> DIGIT_WIDTH;
          result_q    <= DATA_WIDTH'({digit_sum, result_q} >> DIGIT_WIDTH);
          carry_q     <= digit_co;
          digit_cnt_q <= (digit_cnt_q == LAST_DIGIT) ? '0 : digit_cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_rd   = (state_q == IDLE);
  assign out_vld = (state_q == DONE);
  assign s_out   = result_q;
  assign co_out  = carry_q;

endmodule
